fir_output_stage: RTL and testbench
===================================

Name: fir_output_stage

Overview:
- Downstream consumer of the transposed FIR tap chain.
- Accepts the final 2N-bit accumulator (`summed_signal` of the last tap) and applies a right shift with round-half-up.
- Saturates the result to N bits and presents it on a valid/ready stream toward the AXI-Stream master wrapper.
- Provides a sticky saturation flag and a saturating event counter for the register block.

Parameters:
- N, 16, output sample width; the input is 2N bits.
- SHIFT, 15, fractional bits removed (Q15 coefficients); legal range 0..2N-1.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- s_data  in  2N  signed accumulator from the FIR chain.
- s_valid  in  1  s_data valid.
- s_ready  out  1  stage can accept s_data.
- m_data  out  N  signed rounded, saturated sample.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts m_data.
- sat_flag  out  1  sticky: a saturation has occurred since the last clear.
- sat_count  out  CNT_W  number of saturated samples, stops at all-ones.
- sat_clear  in  1  clears sat_flag and sat_count.

Behaviour:
- Reset (sync, reset=1 at posedge clk) clears v1, v2, m_valid, m_data, sat_flag and sat_count to 0. s_ready evaluates to 1 after reset.
- Reset mid-stream discards both in-flight samples with no output.

Pipeline:
- Two register stages, S1 and S2, each with a valid bit (v1, v2). m_valid = v2.
- Stall-chain readiness:
  - adv2 = !v2 | m_ready
  - adv1 = !v1 | adv2
  - s_ready = adv1 (combinational, no s_valid dependence)
- Input transfer when s_valid & s_ready: S1 loads r1 = (sign-extend s_data to 2N+1) + (SHIFT>0 ? 2^(SHIFT-1) : 0), and v1<=1.
- If adv1 holds with no input transfer, v1<=0.
- S2 loads when adv2 holds; if v1, m_data <= sat(r1 >>> SHIFT) and v2<=v1. m_data holds when v1=0.
- While v2 & !m_ready: S2 and m_data hold stable, and S1 holds if v1.
- Latency: 2 cycles from input transfer to m_valid with no backpressure. Throughput is 1 sample/cycle when m_ready=1.

Arithmetic:
- Shift is arithmetic (floor), so rounding is half toward +inf.
- Saturation bounds: if the shifted value > 2^(N-1)-1, output 2^(N-1)-1; if < -2^(N-1), output -2^(N-1); otherwise truncate to N bits.
- sat_event = sample loaded into S2 required clamping. It is counted once per sample, at the S2 load.

Flag and counter:
- sat_event sets sat_flag and increments sat_count, which stops at 2^CNT_W-1 (no wrap).
- sat_clear has priority over a sat_event in the same cycle: result is flag=0, count=0.

Boundaries:
- Simultaneous output handshake and new input with both stages full: all three transfers occur in the same cycle, no bubble.
- s_valid while s_ready=0: sample not taken; the upstream holds it.

Decomposition:
- Shared FIR package holds:
  - function sat_round(value, N, SHIFT) returning the saturated value and the clamp bit
  - localparams MAX_S = 2^(N-1)-1 and MIN_S = -2^(N-1)
- Reuse the package in the tap and coefficient blocks.
- One sub-module is natural: `sat_counter` (CNT_W saturating counter with clear priority). Everything else stays flat.

Test Plan:
- 1. Rounding boundaries, m_ready=1, N=16, SHIFT=15:
  - s_data 0x00004000 -> m_data 1, sat_flag=0
  - 0x00003FFF -> 0
  - 0xFFFFC000 -> 0
  - 0xFFFFBFFF -> -1 (0xFFFF)
  - each output exactly 2 cycles after its input transfer.
- 2. Saturation:
  - 0x7FFFFFFF -> 0x7FFF
  - 0x80000000 -> 0x8000
  - 0x3FFFC000 -> 0x7FFF
  - 0x3FFF8000 -> 0x7FFF with no clamp
  - after the four samples: sat_count=3, sat_flag=1.
- 3. Backpressure: stream 10 ramp samples (k<<15, k=0..9) with m_ready toggled pseudo-randomly -> outputs 0..9 in order, no loss or duplication, m_data stable while m_valid & !m_ready, s_ready=0 only when both stages full and m_ready=0.
- 4. Full-throughput with simultaneous events: hold s_valid=1 and m_ready=1 for 8 cycles -> 8 outputs on consecutive cycles. Drop m_ready for 1 cycle with both stages full -> s_ready=0 that cycle, resume with no bubble.
- 5. Counter saturation and clear:
  - CNT_W=4, 20 saturating samples -> sat_count=15.
  - sat_clear asserted in the same cycle as a sat_event -> count=0, flag=0 next cycle.
- 6. Reset mid-operation: both stages valid and m_ready=0, assert reset for 1 cycle -> next cycle m_valid=0, m_data=0, s_ready=1, sat_flag=0; the held samples never appear.

Source files
------------

// File: rtl/fir_output_stage_pkg.sv
// fir_output_stage_pkg: shared FIR arithmetic helpers (round-shift-saturate)
// and default sample bounds used by the tap, coefficient and output blocks.
package fir_output_stage_pkg;
    localparam int     SAT_W = 64;
    localparam int     N_DEF = 16;
    localparam longint MAX_S = (longint'(1) <<< (N_DEF - 1)) - 1;
    localparam longint MIN_S = -MAX_S - 1;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    clamp;
    } sat_t;

    // Arithmetic shift (floor) followed by clamping into an n-bit signed range.
    function automatic sat_t sat_round(input logic signed [SAT_W-1:0] v, input int n, input int shift);
        logic signed [SAT_W-1:0] sh, mx, mn;
        sat_t r;
        sh = v >>> shift;
        mx = $signed((SAT_W'(1) << (n - 1)) - SAT_W'(1));
        mn = ~mx;
        r.clamp = (sh > mx) || (sh < mn);
        r.value = (sh > mx) ? mx : (sh < mn) ? mn : sh;
        return r;
    endfunction
endpackage

// File: rtl/fir_output_stage_sat_counter.sv
// sat_counter: sticky event flag plus a counter that stops at all-ones;
// clear wins over a coincident event.
module sat_counter #(
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_event,
    output logic             o_flag,
    output logic [CNT_W-1:0] o_count
);
    logic             r_flag;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_flag  <= 1'b0;
            r_count <= '0;
        end else if (i_event) begin
            r_flag  <= 1'b1;
            r_count <= (&r_count) ? r_count : r_count + 1'b1;
        end
    end

    assign o_flag  = r_flag;
    assign o_count = r_count;
endmodule

// File: rtl/fir_output_stage.sv
// fir_output_stage: rounds, saturates and streams the final FIR accumulator
// through a two-stage stall pipeline, tracking saturation events.
module fir_output_stage
    import fir_output_stage_pkg::*;
#(
    parameter int N     = 16,
    parameter int SHIFT = 15,
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [2*N-1:0]   s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [N-1:0]     m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             sat_flag,
    output logic [CNT_W-1:0] sat_count,
    input  logic             sat_clear
);
    localparam int           RS  = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [2*N:0] RND = (SHIFT > 0) ? (2*N+1)'(1) << RS : '0;

    logic           r_v1, r_v2;
    logic [2*N:0]   r_s1;
    logic [N-1:0]   r_mdata;
    logic           w_adv1, w_adv2, w_event, w_unused;
    sat_t           w_sat;

    assign w_adv2  = !r_v2 || m_ready;
    assign w_adv1  = !r_v1 || w_adv2;
    assign s_ready = w_adv1;

    // One guard bit above 2N keeps the rounding add from overflowing.
    assign w_sat    = sat_round(SAT_W'($signed(r_s1)), N, SHIFT);
    assign w_event  = w_adv2 && r_v1 && w_sat.clamp;
    assign w_unused = ^w_sat.value[SAT_W-1:N];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_s1    <= '0;
            r_mdata <= '0;
        end else begin
            if (w_adv1) begin
                r_v1 <= s_valid;
                if (s_valid)
                    r_s1 <= {s_data[2*N-1], s_data} + RND;
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1)
                    r_mdata <= w_sat.value[N-1:0];
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_sat (
        .clk     (clk),
        .reset   (reset),
        .i_clear (sat_clear),
        .i_event (w_event),
        .o_flag  (sat_flag),
        .o_count (sat_count)
    );

    assign m_valid = r_v2;
    assign m_data  = r_mdata;
endmodule

// File: tb/tb_fir_output_stage.sv
// tb_fir_output_stage: directed scoreboard bench for the FIR output stage
// (rounding, saturation, backpressure, counter clear and reset flush).
module tb_fir_output_stage;
    logic        clk, reset, s_valid, s_ready, m_valid, m_ready, sat_flag, sat_clear;
    logic [31:0] s_data;
    logic [15:0] m_data;
    logic [3:0]  sat_count;

    typedef struct { logic [15:0] d; int cyc; } exp_t;
    exp_t        q[$];
    logic [15:0] cur_exp = '0;
    logic [15:0] hold_d = '0;
    logic        hold = 1'b0, chk_lat = 1'b0, rnd = 1'b0;
    int          cyc = 0, n_chk = 0, n_fail = 0;

    fir_output_stage #(.N(16), .SHIFT(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .sat_flag(sat_flag), .sat_count(sat_count), .sat_clear(sat_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (rnd) m_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Handshakes seen at the falling edge are the ones the next rising edge commits.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            hold = 1'b0;
        end else begin
            check("s_ready", 32'(s_ready), (q.size() == 2 && !m_ready) ? 32'd0 : 32'd1);
            if (hold) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(hold_d));
            end
            hold   = m_valid && !m_ready;
            hold_d = m_data;
            if (m_valid && m_ready) begin
                if (q.size() == 0) check("spurious_out", 32'(m_valid), 32'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check("m_data", 32'(m_data), 32'(e.d));
                    if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
                end
            end
            if (s_valid && s_ready) q.push_back('{cur_exp, cyc});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [15:0] e);
        logic ok = 1'b0;
        s_data  = d;
        cur_exp = e;
        s_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
            step();
        end
        check("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 100 && q.size() > 0; i++) step();
        check("drain_empty", 32'(q.size()), 32'd0);
        step();
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; m_ready = 1'b1; sat_clear = 1'b0; s_data = '0;
        step();
        step();
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        step();
        reset = 1'b0;

        // rounding boundaries with exact two-cycle latency
        chk_lat = 1'b1;
        send(32'h0000_4000, 16'h0001);
        send(32'h0000_3FFF, 16'h0000);
        send(32'hFFFF_C000, 16'h0000);
        send(32'hFFFF_BFFF, 16'hFFFF);
        drain();
        chk_lat = 1'b0;
        check("t1_sat_flag", 32'(sat_flag), 32'd0);
        check("t1_sat_count", 32'(sat_count), 32'd0);

        // saturation: three clamps, one in-range maximum
        send(32'h7FFF_FFFF, 16'h7FFF);
        send(32'h8000_0000, 16'h8000);
        send(32'h3FFF_C000, 16'h7FFF);
        send(32'h3FFF_8000, 16'h7FFF);
        drain();
        check("t2_sat_count", 32'(sat_count), 32'd3);
        check("t2_sat_flag", 32'(sat_flag), 32'd1);

        // ramp under random backpressure
        rnd = 1'b1;
        for (int k = 0; k < 10; k++) send(32'(k) << 15, 16'(k));
        s_valid = 1'b0;
        rnd = 1'b0;
        m_ready = 1'b1;
        drain();

        // full throughput, one-cycle stall with both stages full, no bubble
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data  = 32'(100 + i) << 15;
            cur_exp = 16'(100 + i);
            @(negedge clk);
            if (i >= 2) check("t4_stream_valid", 32'(m_valid), 32'd1);
            step();
        end
        s_data = 32'(108) << 15; cur_exp = 16'd108; m_ready = 1'b0;
        @(negedge clk);
        check("t4_stall_s_ready", 32'(s_ready), 32'd0);
        check("t4_stall_valid", 32'(m_valid), 32'd1);
        step();
        m_ready = 1'b1;
        @(negedge clk);
        check("t4_resume_s_ready", 32'(s_ready), 32'd1);
        check("t4_resume_valid", 32'(m_valid), 32'd1);
        step();
        s_data = 32'(109) << 15; cur_exp = 16'd109;
        @(negedge clk);
        check("t4_run_valid", 32'(m_valid), 32'd1);
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t4_tail_valid", 32'(m_valid), 32'd1);
            step();
        end
        drain();

        // counter stops at all-ones, then clear beats a coincident event
        for (int i = 0; i < 20; i++) send(32'h7FFF_FFFF, 16'h7FFF);
        drain();
        check("t5_count_sat", 32'(sat_count), 32'd15);
        check("t5_flag_set", 32'(sat_flag), 32'd1);
        send(32'h8000_0000, 16'h8000);
        s_valid = 1'b0;
        sat_clear = 1'b1;
        step();
        sat_clear = 1'b0;
        check("t5_clear_count", 32'(sat_count), 32'd0);
        check("t5_clear_flag", 32'(sat_flag), 32'd0);
        drain();

        // reset with both stages holding samples
        m_ready = 1'b0;
        send(32'h7FFF_FFFF, 16'h7FFF);
        send(32'h8000_0000, 16'h8000);
        s_valid = 1'b0;
        @(negedge clk);
        check("t6_full_s_ready", 32'(s_ready), 32'd0);
        check("t6_pre_flag", 32'(sat_flag), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("t6_m_valid", 32'(m_valid), 32'd0);
        check("t6_m_data", 32'(m_data), 32'd0);
        check("t6_s_ready", 32'(s_ready), 32'd1);
        check("t6_sat_flag", 32'(sat_flag), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check("t6_no_ghost", 32'(m_valid), 32'd0);
        end
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
